rom_seq: RTL
============

Name: rom_seq

Overview:
Parametrised ROM sequencer. Holds a synthesis-time initialised word table and streams a programmable window of it (start address, length) over a valid/ready interface.
- Supports one-shot and looped playback, abort, and address wrap-around.
- Sits between constant tables (waveforms, init sequences, LUT scripts) and any streaming consumer in the ice40 library.

Parameters:
m, 8, ROM depth in words; address width AW = $clog2(m), minimum 1
n, 8, word width in bits
data, 0, packed init vector; word k = data[(content_size-1-k)*n +: n], i.e. word 0 is the most significant n bits
content_size, m, number of initialised words (1..m); addresses >= content_size read as 0

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin playback; sampled only in IDLE
stop  in  1  abort playback; sampled only in STREAM
start_addr  in  AW  first word address, latched on accepted start
length  in  AW+1  words per pass (0..m), latched on accepted start
loop  in  1  repeat the pass indefinitely, latched on accepted start
data_o  out  n  current word
valid_o  out  1  data_o is valid
ready_i  in  1  consumer accepts data_o this cycle
last_o  out  1  data_o is the final word of the current pass
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, playback finished normally

Behaviour:
- Reset (rst=1 at an edge): state IDLE; data_o=0, valid_o=0, last_o=0, busy=0, done=0; internal address and count cleared.
- Reset has priority over all inputs, including mid-stream. A word in flight is dropped.
- FSM has two states, IDLE and STREAM.
- IDLE, start=1, length>0:
  - latch start_addr, length, loop; load data_o <= rom[start_addr]; remaining <= length.
  - Go to STREAM. valid_o=1 on the next cycle, so latency is 1 clock.
- IDLE, start=1, length=0: stay IDLE. done=1 on the next cycle. No data is emitted.
- Handshake: a transfer occurs when valid_o && ready_i at an edge.
- While valid_o && !ready_i, data_o and last_o are held stable.
- On each transfer, address advances by +1 and wraps from m-1 to 0. data_o loads rom[next address] on the same edge, so throughput is 1 word/clock with ready_i held high.
- last_o = valid_o && (remaining == 1).
- Transfer with remaining==1 and loop=0: next cycle valid_o=0, busy=0, done=1 (one cycle), state IDLE.
- Transfer with remaining==1 and loop=1: address reloads from the latched start_addr, remaining reloads from the latched length, valid_o stays 1, and there is no bubble. done is never asserted while looping.
- stop=1 in STREAM: next cycle valid_o=0, last_o=0, busy=0, state IDLE, no done pulse.
  - stop has priority over a simultaneous transfer; that word counts as delivered to the consumer.
- start while busy is ignored. Inputs start_addr, length and loop are ignored outside an accepted start.
- stop in IDLE is ignored. start and stop in the same IDLE cycle start playback.
- length=m with any start_addr reads each address exactly once per pass.
- Implementation: ROM as a register array initialised from data, read through the data_o register. Inference as iCE40 BRAM is permitted.

Optional Feature:
ROM_SEQ_DIR_EN:
- Defined: adds input port dir (1 bit), latched on accepted start.
  - dir=0: address increments per transfer.
  - dir=1: address decrements per transfer, wrapping 0 -> m-1.
  - The loop reload restores start_addr in both directions.
- Undefined: no dir port; address always increments.

Test Plan:
- All scenarios use m=8, n=4, data={4'd0,4'd1,4'd2,4'd3,4'd4,4'd5}, content_size=6.
- One-shot: start_addr=0, length=6, loop=0, ready_i=1 -> valid_o for 6 cycles starting 1 cycle after start, data_o 0,1,2,3,4,5; last_o only with 5; done high 1 cycle after the last transfer; busy falls at the same time.
- Backpressure: same stream, ready_i toggled 1,0,0,1,... -> data_o/last_o stable while ready_i=0; consumer receives exactly 0..5 with no duplicates or gaps.
- Wrap and out-of-content: start_addr=6, length=4 -> addresses 6,7,0,1 give data_o 0,0,0,1; last_o with the fourth word.
- Loop and abort: start_addr=2, length=3, loop=1, ready_i=1 -> 2,3,4,2,3,4,... with no bubble and last_o on each 4; stop pulse -> valid_o=0 next cycle, done stays 0.
- Reset and ignores:
  - rst asserted mid-stream -> next cycle all outputs 0.
  - start during busy -> no effect on the stream.
  - length=0 start -> no valid_o, done pulse 1 cycle later.
- With ROM_SEQ_DIR_EN: dir=1, start_addr=1, length=3 -> 1,0,0 (addresses 1,0,7).

Source files
------------

// File: rtl/rom_seq.sv
// rom_seq: constant word table streamed as a programmable window over valid/ready.
//
// Parameters
//   m            ROM depth in words (address width AW = $clog2(m), minimum 1)
//   n            word width in bits
//   content_size number of initialised words; addresses >= content_size read 0
//   data         packed init vector, word 0 in the most significant n bits
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        begin playback (IDLE only); start_addr/length/loop latched here
//   stop         abort playback (STREAM only), no done pulse
//   data_o       current word, valid_o qualifies it, ready_i accepts it
//   last_o       data_o is the final word of the current pass
//   busy         playback in progress
//   done         one-cycle pulse on normal completion (or zero-length start)
//
// Optional build macro
//   ROM_SEQ_DIR_EN  adds input dir: 0 = address increments, 1 = decrements
module rom_seq #(
    parameter int unsigned m            = 8,
    parameter int unsigned n            = 8,
    parameter int unsigned content_size = m,
    parameter logic [content_size*n-1:0] data = '0,
    localparam int unsigned AW = (m > 1) ? $clog2(m) : 1,
    localparam int unsigned LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] length,
    input  logic          loop,
`ifdef ROM_SEQ_DIR_EN
    input  logic          dir,
`endif
    output logic [n-1:0]  data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Constant word table; untouched addresses read as zero.
    logic [n-1:0] rom [m];

    for (genvar k = 0; k < int'(m); k++) begin : g_rom
        if (k < int'(content_size)) begin : g_init
            assign rom[k] = data[(int'(content_size) - 1 - k)*int'(n) +: int'(n)];
        end else begin : g_zero
            assign rom[k] = '0;
        end
    end

    state_t        state, state_n;
    logic [AW-1:0] addr, addr_n;
    logic [LW-1:0] remaining, remaining_n;
    logic [AW-1:0] sa_q, sa_n;
    logic [LW-1:0] len_q, len_n;
    logic          loop_q, loop_n;
    logic          down_q, down_n;
    logic [n-1:0]  data_n;
    logic          valid_n, last_n, busy_n, done_n;
    logic          dir_in_c;

`ifdef ROM_SEQ_DIR_EN
    assign dir_in_c = dir;
`else
    assign dir_in_c = 1'b0;
`endif

    // Next address with wrap at either end of the table.
    function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a, input logic down);
        if (down) begin
            return (a == '0) ? AW'(m - 1) : a - AW'(1);
        end
        return (a == AW'(m - 1)) ? '0 : a + AW'(1);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            sa_q      <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            down_q    <= 1'b0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            sa_q      <= sa_n;
            len_q     <= len_n;
            loop_q    <= loop_n;
            down_q    <= down_n;
            data_o    <= data_n;
            valid_o   <= valid_n;
            last_o    <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        sa_n        = sa_q;
        len_n       = len_q;
        loop_n      = loop_q;
        down_n      = down_q;
        data_n      = data_o;
        valid_n     = valid_o;
        last_n      = last_o;
        busy_n      = busy;
        done_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        sa_n        = start_addr;
                        len_n       = length;
                        loop_n      = loop;
                        down_n      = dir_in_c;
                        addr_n      = start_addr;
                        remaining_n = length;
                        data_n      = rom[start_addr];
                        valid_n     = 1'b1;
                        last_n      = (length == LW'(1));
                        busy_n      = 1'b1;
                        state_n     = STREAM;
                    end else begin
                        // Empty window: nothing to send, report completion at once.
                        done_n = 1'b1;
                    end
                end
            end

            STREAM: begin
                if (stop) begin
                    // Abort wins over a simultaneous transfer; that word was still taken.
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (valid_o && ready_i) begin
                    if (remaining == LW'(1)) begin
                        if (loop_q) begin
                            // Reload the window with no bubble.
                            addr_n      = sa_q;
                            remaining_n = len_q;
                            data_n      = rom[sa_q];
                            last_n      = (len_q == LW'(1));
                        end else begin
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        addr_n      = step_addr(addr, down_q);
                        remaining_n = remaining - LW'(1);
                        data_n      = rom[addr_n];
                        last_n      = (remaining == LW'(2));
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
